score_accumulator: RTL and testbench

Multi-lane, parametrised score engine for the dance-game datapath. Per lane it detects key presses, grades them against the target row (ROW2) and the missed row (ROW1), and emits one-cycle CORRECT/OFF/WRONG pulses. It also folds all lanes into a saturating running score and a combo counter. It sits between the lane LED shift logic and the score display/HEX driver, and replaces per-lane single-key score tracking.

---
 rtl/score_accumulator.sv | 133 +++++++++++++
 tb/tb_score_accumulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - multi-lane key grading with saturating score and combo counter
//
// Ports:
//   CLOCK          system clock, rising edge
//   RESET          asynchronous active-low reset
//   ENABLE         game active; grading only while high
//   CLEAR          synchronous clear of SCORE/COMBO, suppresses pulses that cycle
//   KEY[LANES]     debounced key level per lane
//   ROW1[LANES]    missed-row LED per lane
//   ROW2[LANES]    target-row LED per lane
//   CORRECT/OFF/WRONG[LANES]  registered one-cycle grade pulses
//   SCORE[SCORE_W] saturating running score
//   COMBO[COMBO_W] saturating consecutive-correct count
//
// Optional feature macro: COMBO_BONUS_EN (CORRECT worth +3 once COMBO >= COMBO_THRESH)
module score_accumulator #(
    parameter int LANES        = 4,
    parameter int SCORE_W      = 10,
    parameter int COMBO_W      = 6,
    parameter int COMBO_THRESH = 8
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               CLEAR,
    input  logic [LANES-1:0]   KEY,
    input  logic [LANES-1:0]   ROW1,
    input  logic [LANES-1:0]   ROW2,
    output logic [LANES-1:0]   CORRECT,
    output logic [LANES-1:0]   OFF,
    output logic [LANES-1:0]   WRONG,
    output logic [SCORE_W-1:0] SCORE,
    output logic [COMBO_W-1:0] COMBO
);

    // Lane counts need one spare bit so the zero-extension below is never empty.
    localparam int CNT_W = $clog2(LANES + 1) + 1;
    // Signed working width: score plus headroom for +-3*LANES.
    localparam int DW    = SCORE_W + 8;
    localparam int CSW   = COMBO_W + CNT_W;

    localparam logic signed [DW-1:0] SCORE_MAX = DW'((64'd1 << SCORE_W) - 64'd1);
    localparam logic [CSW-1:0]       COMBO_MAX = CSW'((64'd1 << COMBO_W) - 64'd1);

    if (LANES < 1 || LANES > 8 || COMBO_THRESH < 0) begin : g_bad_param
        $error("score_accumulator: LANES must be 1..8 and COMBO_THRESH non-negative");
    end

    logic [LANES-1:0]       key_q;
    logic [LANES-1:0]       press;
    logic [LANES-1:0]       hit_c, hit_o, hit_w;
    logic [CNT_W-1:0]       nc, no, nw;
    logic signed [DW-1:0]   nc_s, no_s, nw_s, delta, sum;
    logic [CSW-1:0]         csum;
    logic [SCORE_W-1:0]     score_nxt;
    logic [COMBO_W-1:0]     combo_nxt;
    logic                   grade;
    logic                   bonus;

    always_comb begin
        press = KEY & ~key_q;
        // CLEAR suppresses the pulses as well as the accumulator update.
        grade = ENABLE & ~CLEAR;
        hit_c = press & ROW2 & {LANES{grade}};
        hit_o = press & ~ROW2 & ROW1 & {LANES{grade}};
        hit_w = press & ~ROW2 & ~ROW1 & {LANES{grade}};

        nc = '0;
        no = '0;
        nw = '0;
        for (int i = 0; i < LANES; i++) begin
            nc = nc + CNT_W'(hit_c[i]);
            no = no + CNT_W'(hit_o[i]);
            nw = nw + CNT_W'(hit_w[i]);
        end

`ifdef COMBO_BONUS_EN
        // Uses the registered COMBO, i.e. the value before this edge's update.
        bonus = (32'(COMBO) >= 32'(COMBO_THRESH));
`else
        bonus = 1'b0;
`endif

        nc_s  = $signed(DW'(nc));
        no_s  = $signed(DW'(no));
        nw_s  = $signed(DW'(nw));
        delta = (nc_s <<< 1) + no_s - (nw_s <<< 1) + (bonus ? nc_s : '0);
        sum   = $signed(DW'(SCORE)) + delta;

        if (sum < 0) begin
            score_nxt = '0;
        end else if (sum > SCORE_MAX) begin
            score_nxt = '1;
        end else begin
            score_nxt = sum[SCORE_W-1:0];
        end

        // Any WRONG lane breaks the combo; OFF lanes are neutral.
        csum = CSW'(COMBO) + CSW'(nc);
        if (nw != '0) begin
            combo_nxt = '0;
        end else if (csum > COMBO_MAX) begin
            combo_nxt = '1;
        end else begin
            combo_nxt = csum[COMBO_W-1:0];
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            key_q   <= '0;
            CORRECT <= '0;
            OFF     <= '0;
            WRONG   <= '0;
            SCORE   <= '0;
            COMBO   <= '0;
        end else begin
            // Tracks KEY regardless of ENABLE/CLEAR so held keys never grade later.
            key_q   <= KEY;
            CORRECT <= hit_c;
            OFF     <= hit_o;
            WRONG   <= hit_w;
            if (CLEAR) begin
                SCORE <= '0;
                COMBO <= '0;
            end else begin
                SCORE <= score_nxt;
                COMBO <= combo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - scoreboard bench for score_accumulator
module tb_score_accumulator;

    logic       CLOCK  = 1'b0;
    logic       RESET  = 1'b0;
    logic       ENABLE = 1'b0;
    logic       CLEAR  = 1'b0;
    logic [3:0] KEY    = '0;
    logic [3:0] ROW1   = '0;
    logic [3:0] ROW2   = '0;
    logic [3:0] CORRECT, OFF, WRONG;
    logic [9:0] SCORE;
    logic [5:0] COMBO;

    score_accumulator #(
        .LANES(4), .SCORE_W(10), .COMBO_W(6), .COMBO_THRESH(8)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR),
        .KEY(KEY), .ROW1(ROW1), .ROW2(ROW2),
        .CORRECT(CORRECT), .OFF(OFF), .WRONG(WRONG),
        .SCORE(SCORE), .COMBO(COMBO)
    );

    always #5 CLOCK = ~CLOCK;

`ifdef COMBO_BONUS_EN
    localparam int S_BONUS1 = 19;
    localparam int S_BONUS2 = 25;
`else
    localparam int S_BONUS1 = 18;
    localparam int S_BONUS2 = 22;
`endif

    typedef struct {
        logic [3:0] c;
        logic [3:0] o;
        logic [3:0] w;
        int         s;
        int         cb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic check_all(input string tag, input int c, input int o, input int w,
                             input int s, input int cb);
        check({tag, ".correct"}, int'(CORRECT), c);
        check({tag, ".off"},     int'(OFF),     o);
        check({tag, ".wrong"},   int'(WRONG),   w);
        check({tag, ".score"},   int'(SCORE),   s);
        check({tag, ".combo"},   int'(COMBO),   cb);
    endtask

    // Monitor: each edge that has an outstanding expectation is checked.
    initial begin
        forever begin
            @(posedge CLOCK);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_all("sb", int'(mon_e.c), int'(mon_e.o), int'(mon_e.w), mon_e.s, mon_e.cb);
            end
        end
    end

    task automatic drive(input logic en, input logic clr, input logic [3:0] k,
                         input logic [3:0] r1, input logic [3:0] r2,
                         input logic [3:0] c, input logic [3:0] o, input logic [3:0] w,
                         input int s, input int cb);
        exp_t e;
        @(negedge CLOCK);
        ENABLE = en;
        CLEAR  = clr;
        KEY    = k;
        ROW1   = r1;
        ROW2   = r2;
        e.c = c; e.o = o; e.w = w; e.s = s; e.cb = cb;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge CLOCK);
        #2;
        check("drain_remaining", sb.size(), 0);
    endtask

    initial begin
        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge CLOCK);
        RESET = 1'b1;

        //    en clr key     row1    row2    C       O       W       score cb
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 2, 1);
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2, 1);
        // single lane, then held for five cycles
        drive(1, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4, 2);
        for (int i = 0; i < 5; i++)
            drive(1, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4, 2);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4, 2);
        // simultaneous C/O/W: delta +1, wrong breaks combo
        drive(1, 0, 4'b0111, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 5, 0);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 5, 0);
        // ENABLE low: press ignored, and held key does not grade once enabled
        drive(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 5, 0);
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 5, 0);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 5, 0);
        // CLEAR with a CORRECT press
        drive(1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        // low saturation: 1 - 4 clamps to 0
        drive(1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 0);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        drive(1, 0, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 0, 0);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        // back-to-back press/release/press
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 2, 1);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1);
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4, 2);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4, 2);
        // combo build-up toward the bonus threshold
        drive(1, 0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 12, 6);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 12, 6);
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 14, 7);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 14, 7);
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 16, 8);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16, 8);
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, S_BONUS1, 9);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, S_BONUS1, 9);
        drive(1, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000, S_BONUS2, 11);
        // high saturation: climb by +4 OFF presses (combo stays 0)
        drive(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        for (int k = 1; k <= 255; k++) begin
            drive(1, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4 * k, 0);
            drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4 * k, 0);
        end
        drive(1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1021, 0);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1021, 0);
        drive(1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1022, 0);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1022, 0);
        drive(1, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1023, 2);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1023, 2);
        drive(1, 0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1023, 6);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1023, 6);
        drain();

        // mid-run async reset with lane 0 held high through release
        @(negedge CLOCK);
        KEY  = 4'b0001;
        ROW2 = 4'b0001;
        ROW1 = 4'b0000;
        #2;
        RESET = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLOCK);
        #1;
        check_all("reset_hold", 0, 0, 0, 0, 0);
        @(negedge CLOCK);
        RESET = 1'b1;
        begin
            exp_t e;
            e.c = 4'b0001; e.o = 4'b0000; e.w = 4'b0000; e.s = 2; e.cb = 1;
            sb.push_back(e);
        end
        drive(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1);
        drive(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
